// File: rtl/tetromino_queue.sv
// Purpose: 7-bag tetromino supplier with a QUEUE_DEPTH-entry preview queue for the game-state FSM.
// Latency: a pop is visible the cycle after new_tetromino; a (re)fill takes QUEUE_DEPTH+1 cycles.
// Backpressure: none; pops outside READY, or coinciding with game_start/game_end, are dropped.
// Optional feature: define TETROMINO_FIXED_SEQ_EN to replace the randomizer with a 0..6 repeating sequence.
module tetromino_queue #(
    parameter int          QUEUE_DEPTH = 5,        // legal range 1..7
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_start,
    input  logic       game_end,
    input  logic       new_tetromino,
    output logic [2:0] current_piece,
    output logic       piece_valid,
    output logic [2:0] queue_pieces [QUEUE_DEPTH],
    output logic [6:0] bag_remaining
);

    // An all-zero Galois LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [2:0]  LAST_FILL = 3'(QUEUE_DEPTH);
    localparam logic [6:0]  FULL_BAG  = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic [2:0]  fill_cnt;
    logic [2:0]  draw_type;
    logic [6:0]  bag_cleared;
    logic [6:0]  bag_nxt;
    logic        start_evt;
    logic        do_fill;
    logic        do_pop;

`ifdef TETROMINO_FIXED_SEQ_EN
    logic [2:0]  seq_cnt;
`else
    logic [2:0]  start_idx;
    logic [3:0]  probe;
`endif

    // game_end outranks game_start whenever both arrive together.
    assign start_evt = game_start & ~game_end;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: game_end always wins, then game_start, then fill progress.
    always_comb begin
        state_nxt = state;
        if (game_end) begin
            state_nxt = IDLE;
        end else if (game_start) begin
            state_nxt = FILL;
        end else if (state == FILL && fill_cnt == LAST_FILL) begin
            state_nxt = READY;
        end
    end

    // FSM outputs: valid flag plus the two mutually exclusive draw strobes.
    always_comb begin
        piece_valid = (state == READY);
        do_fill     = (state == FILL)  && !game_end && !game_start;
        do_pop      = (state == READY) && !game_end && !game_start && new_tetromino;
    end

    // Galois LFSR step, taps x^16+x^14+x^13+x^11.
    always_comb begin
        lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
    end

`ifdef TETROMINO_FIXED_SEQ_EN
    // Fixed sequence: the draw is simply the running 0..6 counter.
    always_comb begin
        draw_type = seq_cnt;
    end
`else
    // Bag draw: first still-available type at or after (lfsr mod 7), wrapping.
    // Scanning k from high to low lets the smallest k overwrite the result last.
    always_comb begin
        draw_type = 3'd0;
        start_idx = 3'(lfsr % 16'd7);
        probe     = 4'd0;
        for (int k = 6; k >= 0; k--) begin
            probe = {1'b0, start_idx} + 4'(k);
            if (probe >= 4'd7) begin
                probe = probe - 4'd7;
            end
            if (bag_remaining[probe[2:0]]) begin
                draw_type = probe[2:0];
            end
        end
    end
`endif

    // Remove the drawn type; an emptied bag refills immediately.
    always_comb begin
        bag_cleared = bag_remaining & ~(7'b000_0001 << draw_type);
        bag_nxt     = (bag_cleared == 7'h00) ? FULL_BAG : bag_cleared;
    end

    // Datapath: LFSR free-runs; fill writes by index, pop shifts the queue forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr          <= SEED_EFF;
            bag_remaining <= FULL_BAG;
            fill_cnt      <= 3'd0;
            current_piece <= 3'd0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                queue_pieces[i] <= 3'd0;
            end
`ifdef TETROMINO_FIXED_SEQ_EN
            seq_cnt       <= 3'd0;
`endif
        end else begin
            lfsr <= lfsr_nxt;
            if (start_evt) begin
                bag_remaining <= FULL_BAG;
                fill_cnt      <= 3'd0;
`ifdef TETROMINO_FIXED_SEQ_EN
                seq_cnt       <= 3'd0;
`endif
            end else if (do_fill || do_pop) begin
                bag_remaining <= bag_nxt;
`ifdef TETROMINO_FIXED_SEQ_EN
                seq_cnt       <= (seq_cnt == 3'd6) ? 3'd0 : seq_cnt + 3'd1;
`endif
                if (do_fill) begin
                    fill_cnt <= fill_cnt + 3'd1;
                    if (fill_cnt == 3'd0) begin
                        current_piece <= draw_type;
                    end
                    for (int i = 0; i < QUEUE_DEPTH; i++) begin
                        if (fill_cnt == 3'(i + 1)) begin
                            queue_pieces[i] <= draw_type;
                        end
                    end
                end else begin
                    current_piece <= queue_pieces[0];
                    for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                        queue_pieces[i] <= queue_pieces[i + 1];
                    end
                    queue_pieces[QUEUE_DEPTH-1] <= draw_type;
                end
            end
        end
    end

endmodule

// File: tb/tb_tetromino_queue.sv
// Bench for tetromino_queue: directed sequence with random pop/event patterns,
// checked every cycle against a piece-list model built from the block's rules.
module tb_tetromino_queue;

    localparam int          D    = 5;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_start;
    logic       game_end;
    logic       new_tetromino;
    logic [2:0] current_piece;
    logic       piece_valid;
    logic [2:0] queue_pieces [D];
    logic [6:0] bag_remaining;

    int checks   = 0;
    int failures = 0;

    // Model: mode 0=idle 1=filling 2=ready; m_p[0] is the current piece, m_p[1..D] the preview.
    int         m_mode;
    int         m_filled;
    int         m_seq;
    logic [15:0] m_lfsr;
    logic [6:0]  m_bag;
    logic [2:0]  m_p[$];
    int          obs[$];

    tetromino_queue #(.QUEUE_DEPTH(D), .LFSR_SEED(SEED)) dut (
        .clk           (clk),
        .rst           (rst),
        .game_start    (game_start),
        .game_end      (game_end),
        .new_tetromino (new_tetromino),
        .current_piece (current_piece),
        .piece_valid   (piece_valid),
        .queue_pieces  (queue_pieces),
        .bag_remaining (bag_remaining)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    task automatic m_reset();
        m_mode   = 0;
        m_filled = 0;
        m_seq    = 0;
        m_lfsr   = SEED;
        m_bag    = 7'h7F;
        m_p      = {};
        for (int i = 0; i <= D; i++) m_p.push_back(3'd0);
    endtask

    task automatic m_draw(output logic [2:0] t);
        int c;
        t = 3'd0;
`ifdef TETROMINO_FIXED_SEQ_EN
        c = 0;
        t = 3'(m_seq);
        m_seq = (m_seq + 1) % 7;
`else
        c = int'(m_lfsr) % 7;
        for (int k = 0; k < 7; k++) begin
            if (m_bag[(c + k) % 7]) begin
                t = 3'((c + k) % 7);
                break;
            end
        end
`endif
        m_bag = m_bag & ~(7'(1) << t);
        if (m_bag == 7'h00) m_bag = 7'h7F;
    endtask

    // Applies one clock edge to the model using the inputs as sampled at that edge.
    task automatic m_edge();
        logic [2:0] t;
        if (rst) begin
            m_reset();
            return;
        end
        if (game_end) begin
            m_mode = 0;
        end else if (game_start) begin
            m_mode   = 1;
            m_filled = 0;
            m_bag    = 7'h7F;
            m_seq    = 0;
        end else if (m_mode == 1) begin
            m_draw(t);
            m_p[m_filled] = t;
            m_filled++;
            if (m_filled == D + 1) m_mode = 2;
        end else if (m_mode == 2 && new_tetromino) begin
            m_draw(t);
            void'(m_p.pop_front());
            m_p.push_back(t);
        end
        m_lfsr = lfsr_adv(m_lfsr);
    endtask

    task automatic check_all(input string tag);
        logic [3*(D+1)-1:0] got;
        logic [3*(D+1)-1:0] exp;
        for (int i = 0; i <= D; i++) begin
            got[3*i +: 3] = (i == 0) ? current_piece : queue_pieces[i-1];
            exp[3*i +: 3] = m_p[i];
        end
        checks++;
        assert (piece_valid === (m_mode == 2)) else begin
            failures++;
            $error("FAIL %s piece_valid got=%0b exp=%0b", tag, piece_valid, (m_mode == 2));
        end
        checks++;
        assert (bag_remaining === m_bag) else begin
            failures++;
            $error("FAIL %s bag_remaining got=%h exp=%h", tag, bag_remaining, m_bag);
        end
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s pieces got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        m_edge();
        #1;
        check_all(tag);
    endtask

    task automatic expect_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
        end
    endtask

    initial begin
        int mask;
        rst           = 1'b1;
        game_start    = 1'b0;
        game_end      = 1'b0;
        new_tetromino = 1'b0;
        #3;
        m_reset();
        check_all("reset");
        step("reset_hold");
        step("reset_hold");
        rst = 1'b0;

        // IDLE ignores pops.
        repeat (5) begin
            new_tetromino = 1'($urandom % 2);
            step("idle");
        end

        // Fill with new_tetromino held high: READY exactly 6 edges after the start edge.
        game_start    = 1'b1;
        new_tetromino = 1'b1;
        step("start");
        game_start = 1'b0;
        for (int i = 0; i < D + 1; i++) begin
            step("fill");
            expect_bit("fill_valid_timing", piece_valid, (i == D));
        end
        new_tetromino = 1'b0;
`ifdef TETROMINO_FIXED_SEQ_EN
        checks++;
        assert (current_piece === 3'd0 && queue_pieces[0] === 3'd1 && queue_pieces[4] === 3'd5) else begin
            failures++;
            $error("FAIL fixed_fill got=%0d,%0d,%0d exp=0,1,5", current_piece, queue_pieces[0], queue_pieces[4]);
        end
`endif
        obs = {};
        obs.push_back(int'(current_piece));
        for (int i = 0; i < D; i++) obs.push_back(int'(queue_pieces[i]));

        // 70 pops: the first three back-to-back, the rest with random gaps.
        for (int n = 0; n < 70; n++) begin
            new_tetromino = 1'b1;
            step("pop");
            obs.push_back(int'(queue_pieces[D-1]));
            if (obs.size() % 7 == 0) begin
                checks++;
                assert (bag_remaining === 7'h7F) else begin
                    failures++;
                    $error("FAIL bag_boundary got=%h exp=7f", bag_remaining);
                end
            end
`ifdef TETROMINO_FIXED_SEQ_EN
            if (n == 2) begin
                checks++;
                assert (current_piece === 3'd3 && queue_pieces[0] === 3'd4 && queue_pieces[2] === 3'd6
                        && queue_pieces[3] === 3'd0 && queue_pieces[4] === 3'd1) else begin
                    failures++;
                    $error("FAIL fixed_pop3 got=%0d,%0d,%0d exp=3,4,1", current_piece, queue_pieces[0], queue_pieces[4]);
                end
            end
`endif
            if (n >= 2 && ($urandom % 2) == 1) begin
                new_tetromino = 1'b0;
                step("pop_gap");
            end
        end
        new_tetromino = 1'b0;

        // Every aligned 7-draw window holds each type exactly once.
        for (int w = 0; w + 7 <= obs.size(); w += 7) begin
            mask = 0;
            for (int j = 0; j < 7; j++) mask |= (1 << obs[w + j]);
            checks++;
            assert (mask === 32'h7F) else begin
                failures++;
                $error("FAIL bag_window%0d got=%h exp=7f", w / 7, mask);
            end
        end

        // game_start and new_tetromino together in READY: pop dropped, full refill.
        game_start    = 1'b1;
        new_tetromino = 1'b1;
        step("restart_pop");
        expect_bit("restart_valid", piece_valid, 1'b0);
        game_start    = 1'b0;
        new_tetromino = 1'b0;
        for (int i = 0; i < D + 1; i++) begin
            step("refill");
            expect_bit("refill_valid_timing", piece_valid, (i == D));
        end
`ifdef TETROMINO_FIXED_SEQ_EN
        checks++;
        assert (current_piece === 3'd0) else begin
            failures++;
            $error("FAIL fixed_restart got=%0d exp=0", current_piece);
        end
`endif

        // game_end with a pop: back to IDLE, entries held.
        game_end      = 1'b1;
        new_tetromino = 1'b1;
        step("game_end");
        game_end      = 1'b0;
        new_tetromino = 1'b0;
        repeat (3) step("after_end");

        // Asynchronous reset in the middle of a fill.
        game_start = 1'b1;
        step("start2");
        game_start = 1'b0;
        repeat (2) step("fill2");
        #1;
        rst = 1'b1;
        #1;
        m_reset();
        check_all("async_rst");
        step("rst_hold");
        rst = 1'b0;
        step("post_rst");
        game_start = 1'b1;
        step("start3");
        game_start = 1'b0;
        for (int i = 0; i < D + 1; i++) step("fill3");
        expect_bit("fill3_ready", piece_valid, 1'b1);

        // Random mix of events.
        repeat (400) begin
            game_start    = ($urandom % 40) == 0;
            game_end      = ($urandom % 60) == 0;
            new_tetromino = 1'($urandom % 2);
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tetromino_queue.md
Name: tetromino_queue

Overview:
- Supplies tetrominoes to the game-state FSM. Responds to its one-cycle new_tetromino pulse by presenting the next piece on current_piece and refilling a preview queue.
- Pieces come from a 7-bag randomizer: each consecutive, aligned group of 7 draws contains every type exactly once.
- Sits between the game-state FSM (request side) and the falling-tetromino and preview renderers (consumers).

Parameters:
- QUEUE_DEPTH, 5, number of preview entries behind current_piece (legal range 1-7).
- LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR. A value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- game_start  input  1  pulse: clear and refill the queue
- game_end  input  1  pulse: return to IDLE
- new_tetromino  input  1  one-cycle pop request from the game-state FSM
- current_piece  output  3  piece to spawn; I=0, O=1, T=2, S=3, Z=4, J=5, L=6
- piece_valid  output  1  current_piece and queue_pieces are meaningful
- queue_pieces  output  3 x QUEUE_DEPTH  unpacked array of preview pieces; [0] is next
- bag_remaining  output  7  types not yet drawn from the current bag; bit n = type n

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, current_piece=0, queue_pieces all 0, piece_valid=0.
  - bag_remaining=7'h7F, LFSR=LFSR_SEED.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11 (mask 16'hB400).
  - Advances every cycle in every state, including IDLE. It is never reseeded except by rst, so successive games differ.
- Draw (combinational):
  - c = LFSR mod 7, a 3-bit value.
  - Selected type = bag_remaining bit at index (c+k) mod 7 for the smallest k in 0..6 whose bit is set.
  - A draw clears that bit. If the result would be 0, bag_remaining reloads to 7'h7F in the same cycle.
- State IDLE: piece_valid=0; new_tetromino is ignored. game_start -> FILL, and bag_remaining reloads to 7'h7F.
- State FILL:
  - Lasts exactly QUEUE_DEPTH+1 cycles, one draw per cycle.
  - Draw 0 writes current_piece; draw i writes queue_pieces[i-1].
  - A 3-bit fill counter tracks progress. After the last write -> READY.
  - piece_valid=0 throughout; new_tetromino is ignored (not queued).
- State READY: piece_valid=1. On new_tetromino, in a single cycle:
  - current_piece <= queue_pieces[0];
  - queue_pieces[i] <= queue_pieces[i+1];
  - queue_pieces[QUEUE_DEPTH-1] <= a new draw.
  - Back-to-back pops on consecutive cycles are supported, one piece per cycle.
- Latency: pop result is visible on the cycle after new_tetromino is sampled.
- Priority when events coincide: rst > game_end > game_start > new_tetromino.
  - game_end in any state -> IDLE, piece_valid=0; entries are held.
  - game_start in FILL or READY restarts FILL: counter cleared, bag reloaded.
  - A new_tetromino in the same cycle as game_start or game_end is dropped.
- Reset asserted mid-FILL or mid-pop: all state returns to reset values immediately.

Optional Feature:
- Macro: TETROMINO_FIXED_SEQ_EN.
- When defined:
  - The randomizer is bypassed. Draws follow 0,1,2,3,4,5,6,0,... from a 3-bit counter.
  - The counter resets to 0 on rst and on game_start.
  - bag_remaining still tracks draws as in the randomized mode, so the 7-bag property is preserved.
- When undefined: LFSR/bag draw as specified above, and the fixed-sequence counter is absent.

Test Plan:
- FIXED_SEQ, QUEUE_DEPTH=5, game_start pulsed at cycle 0 -> FILL during cycles 1-6; from cycle 7, piece_valid=1, current_piece=0, queue_pieces={1,2,3,4,5}.
- FIXED_SEQ, READY, pop 3 cycles back-to-back -> current_piece goes 1,2,3; queue_pieces ends {4,5,6,0,1}.
- Random mode, 70 pops after fill -> every aligned 7-draw window (fill draws included) contains types 0-6 exactly once; bag_remaining=7'h7F at each window boundary.
- new_tetromino held high throughout FILL -> ignored; READY still reached at cycle 7 with current_piece equal to draw 0.
- rst asserted at FILL cycle 3 -> asynchronously piece_valid=0, queue_pieces all 0, state IDLE; a subsequent game_start fills normally.
- In READY, game_start and new_tetromino asserted in the same cycle -> pop dropped, piece_valid=0 for 6 cycles, then a fresh queue; under FIXED_SEQ it restarts at current_piece=0.
